// File: rtl/mult_sequencer_if.sv
// Request/response bundle between EX-stage decode and the multiply sequencer.
// The slave modport is the sequencer's view; master is the pipeline's view.
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             flush_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, flush_i, data1_i, data2_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, flush_i, data1_i, data2_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/mult_sequencer.sv
// Shift-add multiplier: WIDTH fixed iterations, low WIDTH product bits, and
// a pipeline stall that drops in the DONE cycle so the result advances.
module mult_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mult_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, done_q;
  logic               accept;
  logic [WIDTH-1:0]   acc_sum;

  assign accept  = bus.start_i & ~bus.flush_i;
  // Carry out of the add is dropped: only the low product bits are kept.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d  = BUSY;
          mcand_d  = bus.data1_i;
          mplier_d = bus.data2_i;
          acc_d    = '0;
          cnt_d    = CNT_W'(WIDTH);
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = acc_sum;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush abandons the operation without publishing a partial product.
    if (bus.flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= (state_d == BUSY);
      done_q   <= (state_d == DONE);
    end
  end

  // Stall covers the request cycle too, so the multiply holds in EX.
  assign bus.stall_o  = (state_q == BUSY) |
                        (((state_q == IDLE) | (state_q == DONE)) & accept);
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: 32-bit and 8-bit builds side by side.
module tb_mult_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   saw_done;

  always #5 clk = ~clk;

  mult_sequencer_if #(.WIDTH(32)) bus32 ();
  mult_sequencer_if #(.WIDTH(8))  bus8  ();

  mult_sequencer #(.WIDTH(32), .CNT_W(6)) u_dut32 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus32)
  );

  mult_sequencer #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0: present the request and check the combinational stall.
  task automatic begin_op(input logic [31:0] a, input logic [31:0] b);
    bus32.data1_i = a;
    bus32.data2_i = b;
    bus32.start_i = 1'b1;
    bus32.flush_i = 1'b0;
    #1;
    chk("stall_c0", 32'(bus32.stall_o), 32'd1);
  endtask

  // Cycles 1..32 busy, cycle 33 done with the product.
  task automatic wait_done(input logic [31:0] exp, input string tag);
    for (int i = 1; i <= 32; i++) begin
      tick();
      bus32.start_i = 1'b0;
      chk("busy_iter", {29'd0, bus32.busy_o, bus32.stall_o, bus32.done_o}, 32'b110);
    end
    tick();
    chk({tag, "_done"},   {30'd0, bus32.done_o, bus32.busy_o}, 32'b10);
    chk({tag, "_stall"},  32'(bus32.stall_o), 32'd0);
    chk({tag, "_result"}, bus32.result_o, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus32.start_i = 1'b0; bus32.flush_i = 1'b0; bus32.data1_i = '0; bus32.data2_i = '0;
    bus8.start_i  = 1'b0; bus8.flush_i  = 1'b0; bus8.data1_i  = '0; bus8.data2_i  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_outs32", {bus32.result_o[28:0], bus32.busy_o, bus32.done_o, bus32.stall_o}, 32'd0);
    chk("rst_res32",  bus32.result_o, 32'd0);
    chk("rst_outs8",  {20'd0, bus8.result_o, bus8.busy_o, bus8.done_o, bus8.stall_o}, 32'd0);

    // 7*6 with stall/busy/done timing and result hold
    begin_op(32'd7, 32'd6);
    wait_done(32'd42, "mul7x6");
    tick();
    chk("hold42_done",   32'(bus32.done_o), 32'd0);
    chk("hold42_result", bus32.result_o, 32'd42);
    tick();
    chk("hold42_result2", bus32.result_o, 32'd42);

    // Overflow and signed-pattern products
    begin_op(32'hFFFF_FFFF, 32'd2);
    wait_done(32'hFFFF_FFFE, "mulFFx2");
    tick();
    begin_op(32'h0001_0000, 32'h0001_0000);
    wait_done(32'h0000_0000, "mul2p32");
    tick();
    begin_op(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(32'h8000_0000, "mulMinx-1");

    // Back-to-back: start 3*5 in the DONE cycle of the previous op
    begin_op(32'd3, 32'd5);
    chk("b2b_prev_result", bus32.result_o, 32'h8000_0000);
    wait_done(32'd15, "mul3x5");
    tick();

    // Flush in cycle 10 of 9*9
    begin_op(32'd9, 32'd9);
    for (int i = 1; i <= 9; i++) begin
      tick();
      bus32.start_i = 1'b0;
    end
    tick();
    bus32.flush_i = 1'b1;
    tick();
    bus32.flush_i = 1'b0;
    chk("flush_outs",   {29'd0, bus32.busy_o, bus32.stall_o, bus32.done_o}, 32'd0);
    chk("flush_result", bus32.result_o, 32'd15);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus32.done_o) saw_done = 1'b1;
    end
    chk("flush_no_done", 32'(saw_done), 32'd0);
    chk("flush_result_hold", bus32.result_o, 32'd15);
    begin_op(32'd2, 32'd3);
    wait_done(32'd6, "mul2x3");
    tick();

    // Reset in cycle 15 of 4*4
    begin_op(32'd4, 32'd4);
    for (int i = 1; i <= 15; i++) begin
      tick();
      bus32.start_i = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_flags",  {29'd0, bus32.busy_o, bus32.stall_o, bus32.done_o}, 32'd0);
    chk("midrst_result", bus32.result_o, 32'd0);

    // start and flush together in IDLE: nothing starts
    bus32.start_i = 1'b1;
    bus32.flush_i = 1'b1;
    #1;
    chk("startflush_stall", 32'(bus32.stall_o), 32'd0);
    tick();
    chk("startflush_busy", {30'd0, bus32.busy_o, bus32.stall_o}, 32'd0);
    bus32.start_i = 1'b0;
    bus32.flush_i = 1'b0;

    // 8-bit build: 13*11 done in cycle 9, then 255*255
    bus8.data1_i = 8'd13;
    bus8.data2_i = 8'd11;
    bus8.start_i = 1'b1;
    #1;
    chk("w8_stall_c0", 32'(bus8.stall_o), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      bus8.start_i = 1'b0;
      chk("w8_busy", {30'd0, bus8.busy_o, bus8.done_o}, 32'b10);
    end
    tick();
    chk("w8_done",   {30'd0, bus8.done_o, bus8.stall_o}, 32'b10);
    chk("w8_result", 32'(bus8.result_o), 32'h8F);
    tick();
    bus8.data1_i = 8'd255;
    bus8.data2_i = 8'd255;
    bus8.start_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      bus8.start_i = 1'b0;
    end
    tick();
    chk("w8_ff_done",   32'(bus8.done_o), 32'd1);
    chk("w8_ff_result", 32'(bus8.result_o), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
